wb_regfile: RTL and testbench

Writeback stage and architectural register file for the 5-stage pipelined CPU. Consumes the MEM/WB pipeline register outputs and selects the writeback value: ALU result, load data extracted and extended per opcode, or link address. Commits that value into a 32×32 register file whose two asynchronous read ports feed the ID stage. Also exports the writeback value and destination for EX-stage forwarding, plus a committed-write counter for debug.

---
 rtl/wb_regfile.sv | 92 +++++++++
 tb/tb_wb_regfile.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: writeback select, 32x32 register file with async reads.
// Optional macro WB_BYPASS_EN: write-through from the writeback value to the read ports.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_RegWrite,
  input  logic        wb_MemtoReg,
  input  logic        wb_Jump,
  input  logic [5:0]  wb_opcode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_rd,
  input  logic [31:0] wb_alu_out,
  input  logic [4:0]  wb_mux,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] fwd_data,
  output logic [4:0]  fwd_dest,
  output logic        fwd_valid,
  output logic [31:0] wr_count
);

  logic [31:0] regs_q [32];
  logic [31:0] cnt_q;
  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign off = wb_alu_out[1:0];

  // big-endian: offset 0 is the most significant byte
  always_comb begin
    ld_byte = 8'h00;
    unique case (off)
      2'd0: ld_byte = wb_rd[31:24];
      2'd1: ld_byte = wb_rd[23:16];
      2'd2: ld_byte = wb_rd[15:8];
      2'd3: ld_byte = wb_rd[7:0];
    endcase
  end

  assign ld_half = off[1] ? wb_rd[15:0] : wb_rd[31:16];

  always_comb begin
    ld_data = wb_rd;
    case (wb_opcode)
      6'h20:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      6'h24:   ld_data = {24'h0, ld_byte};
      6'h21:   ld_data = {{16{ld_half[15]}}, ld_half};
      6'h25:   ld_data = {16'h0, ld_half};
      default: ld_data = wb_rd;
    endcase
  end

  always_comb begin
    fwd_data = wb_alu_out;
    if (wb_Jump)
      fwd_data = wb_pc;
    else if (wb_MemtoReg)
      fwd_data = ld_data;
  end

  assign fwd_dest  = wb_Jump ? 5'd31 : wb_mux;
  assign fwd_valid = wb_RegWrite && (fwd_dest != 5'd0);

  // r0 is never written because fwd_valid excludes it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        regs_q[i] <= 32'h0;
      cnt_q <= 32'h0;
    end else if (fwd_valid) begin
      regs_q[fwd_dest] <= fwd_data;
      cnt_q <= cnt_q + 32'd1;
    end
  end

`ifdef WB_BYPASS_EN
  assign rs_data = (fwd_valid && rs_addr == fwd_dest) ?
                   fwd_data : regs_q[rs_addr];
  assign rt_data = (fwd_valid && rt_addr == fwd_dest) ?
                   fwd_data : regs_q[rt_addr];
`else
  assign rs_data = regs_q[rs_addr];
  assign rt_data = regs_q[rt_addr];
`endif

  assign wr_count = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: table vectors, directed corners and random
// stimulus against a behavioural register-file model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_RegWrite, wb_MemtoReg, wb_Jump;
  logic [5:0]  wb_opcode;
  logic [31:0] wb_pc, wb_rd, wb_alu_out;
  logic [4:0]  wb_mux, rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data, fwd_data, wr_count;
  logic [4:0]  fwd_dest;
  logic        fwd_valid;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] model [32];
  logic [31:0] mcount;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
    .wb_Jump(wb_Jump), .wb_opcode(wb_opcode), .wb_pc(wb_pc),
    .wb_rd(wb_rd), .wb_alu_out(wb_alu_out), .wb_mux(wb_mux),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .fwd_data(fwd_data), .fwd_dest(fwd_dest),
    .fwd_valid(fwd_valid), .wr_count(wr_count)
  );

  typedef struct {
    logic [5:0]  op;
    logic [1:0]  off;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_tab [6];

  function automatic logic [31:0] m_load(logic [5:0] op,
                                         logic [31:0] rd,
                                         logic [1:0] o);
    logic [31:0] b, h;
    b = (rd >> (8 * (3 - int'(o)))) & 32'hFF;
    h = (rd >> (o[1] ? 0 : 16)) & 32'hFFFF;
    case (op)
      6'h20:   return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      6'h24:   return b;
      6'h21:   return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      6'h25:   return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] m_data();
    if (wb_Jump) return wb_pc;
    if (wb_MemtoReg) return m_load(wb_opcode, wb_rd, wb_alu_out[1:0]);
    return wb_alu_out;
  endfunction

  function automatic logic [4:0] m_dest();
    return wb_Jump ? 5'd31 : wb_mux;
  endfunction

  function automatic logic m_valid();
    return wb_RegWrite && (m_dest() != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (m_valid() && a == m_dest()) return m_data();
`endif
    return model[a];
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(logic rw, logic mtr, logic j, logic [5:0] op,
                       logic [31:0] pc, logic [31:0] rd,
                       logic [31:0] alu, logic [4:0] mux,
                       logic [4:0] ra, logic [4:0] rb);
    @(negedge clk);
    wb_RegWrite = rw; wb_MemtoReg = mtr; wb_Jump = j;
    wb_opcode = op; wb_pc = pc; wb_rd = rd; wb_alu_out = alu;
    wb_mux = mux; rs_addr = ra; rt_addr = rb;
    #1;
  endtask

  task automatic idle(logic [4:0] ra, logic [4:0] rb);
    drive(0, 0, 0, 6'h0, 32'h0, 32'h0, 32'h0, 5'd0, ra, rb);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      mcount = 32'h0;
    end else if (m_valid()) begin
      model[m_dest()] = m_data();
      mcount = mcount + 32'd1;
    end
    #1;
  endtask

  initial begin
    logic [5:0] ops [6];
    ops[0] = 6'h20; ops[1] = 6'h21; ops[2] = 6'h23;
    ops[3] = 6'h24; ops[4] = 6'h25; ops[5] = 6'h0F;

    ld_tab[0] = '{6'h20, 2'd0, 32'hFFFF_FF80};
    ld_tab[1] = '{6'h24, 2'd0, 32'h0000_0080};
    ld_tab[2] = '{6'h20, 2'd2, 32'h0000_007F};
    ld_tab[3] = '{6'h21, 2'd2, 32'h0000_7F01};
    ld_tab[4] = '{6'h25, 2'd0, 32'h0000_80FF};
    ld_tab[5] = '{6'h23, 2'd1, 32'h80FF_7F01};

    for (int i = 0; i < 32; i++) model[i] = 32'hx;
    mcount = 32'hx;
    rst = 1'b1;
    idle(0, 31);
    tick();
    tick();
    rst = 1'b0;
    idle(0, 31);
    chk("reset_count", wr_count, 32'h0);
    chk("reset_r0", rs_data, 32'h0);
    chk("reset_r31", rt_data, 32'h0);

    drive(1, 0, 0, 6'h0, 32'h0, 32'h0, 32'h1234_5678, 5'd5, 5'd5, 5'd0);
    chk("alu_fwd_data", fwd_data, 32'h1234_5678);
    chk("alu_fwd_dest", 32'(fwd_dest), 32'd5);
    chk("alu_fwd_valid", 32'(fwd_valid), 32'd1);
    tick();
    idle(5, 0);
    chk("alu_r5", rs_data, 32'h1234_5678);
    chk("alu_count", wr_count, 32'd1);
    drive(1, 0, 0, 6'h0, 32'h0, 32'h0, 32'h1234_5678, 5'd0, 5'd0, 5'd0);
    chk("r0_fwd_valid", 32'(fwd_valid), 32'd0);
    tick();
    idle(0, 5);
    chk("r0_read", rs_data, 32'h0);
    chk("r0_count", wr_count, 32'd1);

    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 0, ld_tab[i].op, 32'h0, 32'h80FF_7F01,
            {30'h0400_0000, ld_tab[i].off}, 5'd10, 5'd0, 5'd0);
      chk($sformatf("load%0d_fwd", i), fwd_data, ld_tab[i].exp);
      tick();
      idle(10, 0);
      chk($sformatf("load%0d_reg", i), rs_data, ld_tab[i].exp);
    end

    drive(1, 0, 1, 6'h0, 32'h0040_0008, 32'h0, 32'hAAAA_5555,
          5'd7, 5'd0, 5'd0);
    chk("link_fwd_dest", 32'(fwd_dest), 32'd31);
    chk("link_fwd_data", fwd_data, 32'h0040_0008);
    tick();
    idle(31, 7);
    chk("link_r31", rs_data, 32'h0040_0008);
    chk("link_r7", rt_data, 32'h0);
    drive(0, 0, 1, 6'h0, 32'h1111_0000, 32'h0, 32'h0, 5'd7, 5'd0, 5'd0);
    chk("jump_norw_valid", 32'(fwd_valid), 32'd0);
    tick();
    idle(31, 0);
    chk("jump_norw_r31", rs_data, 32'h0040_0008);
    chk("jump_norw_count", wr_count, mcount);

    drive(1, 0, 0, 6'h0, 32'h0, 32'h0, 32'h1111_1111, 5'd9, 5'd0, 5'd0);
    tick();
    drive(1, 0, 0, 6'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd9, 5'd9, 5'd9);
`ifdef WB_BYPASS_EN
    chk("bypass_rs_pre", rs_data, 32'hDEAD_BEEF);
    chk("bypass_rt_pre", rt_data, 32'hDEAD_BEEF);
`else
    chk("bypass_rs_pre", rs_data, 32'h1111_1111);
    chk("bypass_rt_pre", rt_data, 32'h1111_1111);
`endif
    tick();
    idle(9, 9);
    chk("bypass_rs_post", rs_data, 32'hDEAD_BEEF);
    chk("bypass_rt_post", rt_data, 32'hDEAD_BEEF);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] ra, rb;
      ra = 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? wb_mux : 5'($urandom_range(0, 31));
      drive(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
            ops[$urandom_range(0, 5)], $urandom, $urandom, $urandom,
            5'($urandom_range(0, 31)), ra, rb);
      rst = ($urandom_range(0, 49) == 0);
      chk("rnd_fwd_data", fwd_data, m_data());
      chk("rnd_fwd_dest", 32'(fwd_dest), 32'(m_dest()));
      chk("rnd_fwd_valid", 32'(fwd_valid), 32'(m_valid()));
      chk("rnd_rs", rs_data, m_read(ra));
      chk("rnd_rt", rt_data, m_read(rb));
      tick();
      rst = 1'b0;
      chk("rnd_count", wr_count, mcount);
    end

    for (int i = 1; i < 32; i++) begin
      drive(1, 0, 0, 6'h0, 32'h0, 32'h0, 32'h0101_0101 * i,
            5'(i), 5'd0, 5'd0);
      tick();
    end
    idle(17, 31);
    chk("preload_r17", rs_data, 32'h1111_1111);
    drive(1, 0, 0, 6'h0, 32'h0, 32'h0, 32'hCAFE_F00D, 5'd3, 5'd0, 5'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      idle(5'(i), 5'(31 - i));
      chk($sformatf("rst_rs%0d", i), rs_data, 32'h0);
      chk($sformatf("rst_rt%0d", i), rt_data, 32'h0);
    end
    chk("rst_count", wr_count, 32'h0);

    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    mcount = 32'hFFFF_FFFF;
    drive(1, 0, 0, 6'h0, 32'h0, 32'h0, 32'h0000_0042, 5'd4, 5'd4, 5'd0);
    chk("wrap_pre", wr_count, 32'hFFFF_FFFF);
    tick();
    idle(4, 0);
    chk("wrap_count", wr_count, 32'h0);
    chk("wrap_model", wr_count, mcount);
    chk("wrap_r4", rs_data, 32'h0000_0042);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
